deadlock_detect_unit: RTL and testbench
=======================================

DEADLOCK_DETECT_UNIT -- requirements
Module: deadlock_detect_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 2: number of dataflow processes.
REQ-002 SHALL have parameter PROC_ID, default 0: index of the monitored process, 0..PROC_NUM-1.
REQ-003 SHALL have parameter BLOCK_THRESHOLD, default 16: consecutive blocked cycles before a probe is launched; minimum 2.
REQ-004 SHALL have parameter PROBE_TIMEOUT, default 8: cycles to wait for own probe return; minimum 2.
REQ-005 SHALL have ports: reset in 1, asynchronous, active-low; clock in 1.
REQ-006 SHALL have port dep_vec in PROC_NUM: processes this process currently waits on; 0 means not blocked; bit PROC_ID is ignored.
REQ-007 SHALL have port probe_in in PROC_NUM: one-hot origin ID of a probe arriving this cycle; 0 means none.
REQ-008 SHALL have port probe_out out PROC_NUM: one-hot origin ID of the probe sent; 0 means none.
REQ-009 SHALL have port probe_dst out PROC_NUM: one-hot destination of probe_out, or of trace_out.
REQ-010 SHALL have port dl_detect_in in 1: global deadlock-detected flag from the report unit.
REQ-011 SHALL have port origin in PROC_NUM: one-hot cycle-start selection from the report unit, valid for one cycle.
REQ-012 SHALL have port token_clear in 1: report unit signals that the current cycle trace is complete.
REQ-013 SHALL have port trace_in in 1: a report trace token arrives this cycle.
REQ-014 SHALL have port trace_out out 1: this unit forwards the trace token toward probe_dst.
REQ-015 SHALL have port dl_out out 1: this process's bit of the report unit's dl_in_vec.

Function
REQ-016 SHALL define the destination as the lowest set bit of dep_vec with bit PROC_ID masked; a zero mask gives destination 0.
REQ-017 SHALL implement states IDLE, WAIT, PROBE, DL and TRACE.
REQ-018 In IDLE, dep_vec!=0 SHALL move to WAIT with blk_cnt=1.
REQ-019 In WAIT, blk_cnt SHALL increment each cycle while the mask is nonzero; a zero mask SHALL return to IDLE with blk_cnt=0.
REQ-020 When blk_cnt==BLOCK_THRESHOLD-1 in WAIT, the unit SHALL register probe_out=1<<PROC_ID and probe_dst=destination for exactly one cycle, then move to PROBE with to_cnt=0.
REQ-021 In PROBE, probe_in==1<<PROC_ID SHALL move to DL.
REQ-022 In PROBE, a zero mask SHALL return to IDLE.
REQ-023 In PROBE, to_cnt==PROBE_TIMEOUT-1 SHALL return to WAIT with blk_cnt=0.
REQ-024 In IDLE, WAIT and PROBE, a foreign nonzero probe_in SHALL be forwarded the next cycle: probe_out=probe_in, probe_dst=current destination. It SHALL be dropped if the mask is zero.
REQ-025 When a forwarded probe collides with the unit's own launch, the own launch SHALL win and the forwarded probe SHALL be dropped.
REQ-026 In DL, dl_out SHALL be 1 while dl_detect_in==0.
REQ-027 In DL, dl_detect_in==1 SHALL move to TRACE and SHALL drive dl_out=0.
REQ-028 In any state, dl_detect_in==1 SHALL move to TRACE, and all probe inputs and outputs SHALL be ignored or zero thereafter.
REQ-029 In TRACE, origin[PROC_ID]==1 SHALL register trace_out=1 and probe_dst=destination for the following cycle only; dl_out SHALL stay 0 that cycle.
REQ-030 In TRACE, trace_in==1 SHALL drive dl_out=1 combinationally in the same cycle.
REQ-031 In TRACE, trace_in==1 on a non-origin unit SHALL register trace_out=1 for the next cycle.
REQ-032 The origin unit SHALL NOT re-forward a trace_in arriving after its own trace launch.
REQ-033 token_clear==1 SHALL clear any pending trace_out and the origin-held flag in the same edge.
REQ-034 trace_in and origin[PROC_ID] arriving together SHALL treat the unit as origin; dl_out SHALL be 0 that cycle.
REQ-035 blk_cnt width SHALL be $clog2(BLOCK_THRESHOLD)+1 and to_cnt width $clog2(PROBE_TIMEOUT)+1; both SHALL saturate and never wrap.

Reset
REQ-036 reset low SHALL immediately force state IDLE, clear all counters and flags, and drive probe_out=0, probe_dst=0, trace_out=0, dl_out=0.
REQ-037 reset asserted mid-probe or mid-trace SHALL discard in-flight tokens with no output glitch after release.

Structure
REQ-038 The shared package deadlock_pkg SHALL hold the state enum and the lowest-set-bit function.
REQ-039 Destination selection SHALL be the single sub-module deadlock_dst_sel, a parameterised priority encoder.

Verification
REQ-040 PROC_NUM=2, PROC_ID=0, dep_vec=2'b10 held 16 cycles -> probe_out=2'b01, probe_dst=2'b10 for one cycle at cycle 16.
REQ-041 Two units cross-blocked, probes looped back -> both reach DL, dl_out=1 until dl_detect_in rises, then dl_out=0.
REQ-042 PROBE with no return for 8 cycles -> WAIT with blk_cnt=0; re-probe 16 cycles later.
REQ-043 origin=2'b01 pulse in TRACE -> trace_out=1 next cycle, dl_out=0; later trace_in -> dl_out=1 same cycle; token_clear clears.
REQ-044 Foreign probe_in=2'b10 on the same cycle as own launch -> probe_out=2'b01 only; foreign probe dropped.
REQ-045 reset deasserted-asserted mid-PROBE -> all outputs 0 in the same cycle, state IDLE after release.

Source files
------------

// File: rtl/deadlock_pkg.sv
// Shared types and helpers for the dataflow deadlock detection units.
package deadlock_pkg;

    // Widest process vector the helper function handles.
    localparam int MAX_PROC = 32;

    // IDLE: not blocked; WAIT: counting blocked cycles; PROBE: own probe in
    // flight; DL: own probe came back; TRACE: global deadlock reporting.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        PROBE = 3'd2,
        DL    = 3'd3,
        TRACE = 3'd4
    } dl_state_e;

    // One-hot of the lowest set bit of v; zero in gives zero out.
    function automatic logic [MAX_PROC-1:0] lowest_set_bit(input logic [MAX_PROC-1:0] v);
        logic [MAX_PROC-1:0] r;
        r = '0;
        for (int i = MAX_PROC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/deadlock_dst_sel.sv
// Picks the process a probe or trace token is sent to: the lowest-numbered
// process this one waits on, never itself.
module deadlock_dst_sel
    import deadlock_pkg::*;
#(
    parameter int N       = 2,
    parameter int SELF_ID = 0
) (
    input  logic [N-1:0] dep_vec,
    output logic [N-1:0] dst,
    output logic         mask_nz
);

    logic [N-1:0]        masked;
    logic [MAX_PROC-1:0] wide_in;
    logic [MAX_PROC-1:0] wide_out;

    // Drop the self-dependency, then priority-encode the remaining waits.
    always_comb begin
        masked          = dep_vec;
        masked[SELF_ID] = 1'b0;
        wide_in         = '0;
        wide_in[N-1:0]  = masked;
        wide_out        = lowest_set_bit(wide_in);
        dst             = wide_out[N-1:0];
        mask_nz         = |wide_out;
    end

endmodule

// File: rtl/deadlock_detect_unit.sv
// Per-process deadlock detector: launches a probe after a run of blocked
// cycles, forwards foreign probes along its wait edge, declares a local
// deadlock when its own probe returns, and takes part in trace reporting.
//
// Token signalling: probe_out/probe_dst and trace_out/probe_dst are
// single-cycle registered pulses with no back-pressure; a token is consumed
// by its receiver in the cycle it is presented, or it is lost.
module deadlock_detect_unit
    import deadlock_pkg::*;
#(
    parameter int PROC_NUM        = 2,
    parameter int PROC_ID         = 0,
    parameter int BLOCK_THRESHOLD = 16,
    parameter int PROBE_TIMEOUT   = 8
) (
    input  logic                reset,
    input  logic                clock,
    input  logic [PROC_NUM-1:0] dep_vec,
    input  logic [PROC_NUM-1:0] probe_in,
    output logic [PROC_NUM-1:0] probe_out,
    output logic [PROC_NUM-1:0] probe_dst,
    input  logic                dl_detect_in,
    input  logic [PROC_NUM-1:0] origin,
    input  logic                token_clear,
    input  logic                trace_in,
    output logic                trace_out,
    output logic                dl_out,
    output dl_state_e           dbg_state
);

    localparam int BLK_W = $clog2(BLOCK_THRESHOLD) + 1;
    localparam int TO_W  = $clog2(PROBE_TIMEOUT) + 1;

    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLOCK_THRESHOLD - 1);
    localparam logic [BLK_W-1:0]    BLK_ONE  = BLK_W'(1);
    localparam logic [BLK_W-1:0]    BLK_MAX  = '1;
    localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(PROBE_TIMEOUT - 1);
    localparam logic [TO_W-1:0]     TO_MAX   = '1;
    localparam logic [PROC_NUM-1:0] OWN_BIT  = PROC_NUM'(1) << PROC_ID;

    dl_state_e           state_q, state_d;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [PROC_NUM-1:0] probe_out_q, probe_out_d;
    logic [PROC_NUM-1:0] probe_dst_q, probe_dst_d;
    logic                trace_out_q, trace_out_d;
    logic                origin_held_q, origin_held_d;

    logic [PROC_NUM-1:0] dst;
    logic                mask_nz;
    logic                fwd_ok;
    logic                is_origin;

    deadlock_dst_sel #(
        .N       (PROC_NUM),
        .SELF_ID (PROC_ID)
    ) u_dst_sel (
        .dep_vec (dep_vec),
        .dst     (dst),
        .mask_nz (mask_nz)
    );

    // Next-state, token pulses and the combinational deadlock flag.
    always_comb begin
        state_d       = state_q;
        blk_cnt_d     = blk_cnt_q;
        to_cnt_d      = to_cnt_q;
        probe_out_d   = '0;
        probe_dst_d   = '0;
        trace_out_d   = 1'b0;
        origin_held_d = origin_held_q;
        dl_out        = 1'b0;
        is_origin     = |(origin & OWN_BIT);

        // Foreign probes only travel while this process is still blocked.
        fwd_ok = (state_q == IDLE || state_q == WAIT || state_q == PROBE) &&
                 !dl_detect_in && mask_nz &&
                 (probe_in != '0) && (probe_in != OWN_BIT);
        if (fwd_ok) begin
            probe_out_d = probe_in;
            probe_dst_d = dst;
        end

        if (dl_detect_in && state_q != TRACE) begin
            // Global deadlock overrides everything; probing stops for good.
            state_d   = TRACE;
            blk_cnt_d = '0;
            to_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mask_nz) begin
                        state_d   = WAIT;
                        blk_cnt_d = BLK_ONE;
                    end
                end
                WAIT: begin
                    if (!mask_nz) begin
                        state_d   = IDLE;
                        blk_cnt_d = '0;
                    end else if (blk_cnt_q == BLK_LAST) begin
                        // Own launch takes the output slot over any forward.
                        probe_out_d = OWN_BIT;
                        probe_dst_d = dst;
                        state_d     = PROBE;
                        to_cnt_d    = '0;
                    end else if (blk_cnt_q != BLK_MAX) begin
                        blk_cnt_d = blk_cnt_q + 1'b1;
                    end
                end
                PROBE: begin
                    if (!mask_nz) begin
                        state_d   = IDLE;
                        blk_cnt_d = '0;
                        to_cnt_d  = '0;
                    end else if (probe_in == OWN_BIT) begin
                        state_d = DL;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d   = WAIT;
                        blk_cnt_d = '0;
                    end else if (to_cnt_q != TO_MAX) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                DL: begin
                    dl_out = 1'b1;
                end
                TRACE: begin
                    dl_out = trace_in && !is_origin;
                    if (token_clear) begin
                        origin_held_d = 1'b0;
                    end else if (is_origin) begin
                        trace_out_d   = 1'b1;
                        probe_dst_d   = dst;
                        origin_held_d = 1'b1;
                    end else if (trace_in && !origin_held_q) begin
                        trace_out_d = 1'b1;
                        probe_dst_d = dst;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered token outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            blk_cnt_q     <= '0;
            to_cnt_q      <= '0;
            probe_out_q   <= '0;
            probe_dst_q   <= '0;
            trace_out_q   <= 1'b0;
            origin_held_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
            to_cnt_q      <= to_cnt_d;
            probe_out_q   <= probe_out_d;
            probe_dst_q   <= probe_dst_d;
            trace_out_q   <= trace_out_d;
            origin_held_q <= origin_held_d;
        end
    end

    assign probe_out = probe_out_q;
    assign probe_dst = probe_dst_q;
    assign trace_out = trace_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_deadlock_detect_unit.sv
// Bench for deadlock_detect_unit (2 processes, monitoring process 0):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_deadlock_detect_unit;

    localparam int N  = 2;
    localparam int ID = 0;
    localparam int BT = 16;
    localparam int PT = 8;
    localparam int OW = 2 * N + 1;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] dep_vec, probe_in, probe_out, probe_dst, origin;
    logic         dl_detect_in, token_clear, trace_in, trace_out, dl_out;
    deadlock_pkg::dl_state_e dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected registered outputs {probe_out, probe_dst, trace_out} per cycle.
    logic [OW-1:0] exp_q[$];

    // Behavioural model of the monitored process.
    typedef enum int {M_FREE, M_BLOCKED, M_PROBING, M_DEAD, M_REPORT} m_mode_t;
    m_mode_t m_mode;
    int      m_run;
    int      m_wait;
    bit      m_held;

    // ---------------- clock / reset / DUT ----------------
    always #5 clock = ~clock;

    deadlock_detect_unit #(
        .PROC_NUM        (N),
        .PROC_ID         (ID),
        .BLOCK_THRESHOLD (BT),
        .PROBE_TIMEOUT   (PT)
    ) dut (
        .reset        (reset),
        .clock        (clock),
        .dep_vec      (dep_vec),
        .probe_in     (probe_in),
        .probe_out    (probe_out),
        .probe_dst    (probe_dst),
        .dl_detect_in (dl_detect_in),
        .origin       (origin),
        .token_clear  (token_clear),
        .trace_in     (trace_in),
        .trace_out    (trace_out),
        .dl_out       (dl_out),
        .dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic deadlock_pkg::dl_state_e model_state();
        case (m_mode)
            M_FREE:    return deadlock_pkg::IDLE;
            M_BLOCKED: return deadlock_pkg::WAIT;
            M_PROBING: return deadlock_pkg::PROBE;
            M_DEAD:    return deadlock_pkg::DL;
            default:   return deadlock_pkg::TRACE;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_FREE;
        m_run  = 0;
        m_wait = 0;
        m_held = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with reset already driven; holds reset low for
    // two cycles and releases it on a falling edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_probe_out", 32'(probe_out), 32'd0);
        check_eq("rst_probe_dst", 32'(probe_dst), 32'd0);
        check_eq("rst_trace_out", 32'(trace_out), 32'd0);
        check_eq("rst_dl_out", 32'(dl_out), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(deadlock_pkg::IDLE));
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("state_after_release", 32'(dbg_state), 32'(deadlock_pkg::IDLE));
    endtask

    // One clock cycle with the inputs currently on the pins: check outputs,
    // advance the model, then let the rising edge happen.
    task automatic cycle();
        logic [OW-1:0] e;
        int  mask, dst, pin, own, po, pd;
        bit  to, dl, foreign, org_me;
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_eq("probe_out", 32'(probe_out), 32'(e[OW-1 -: N]));
        check_eq("probe_dst", 32'(probe_dst), 32'(e[N:1]));
        check_eq("trace_out", 32'(trace_out), 32'(e[0]));
        check_eq("state", 32'(dbg_state), 32'(model_state()));

        own     = 1 << ID;
        mask    = int'(dep_vec) & ~own & ((1 << N) - 1);
        dst     = mask & (-mask);
        pin     = int'(probe_in);
        org_me  = origin[ID];
        foreign = (pin != 0) && (pin != own) && (mask != 0);

        dl = (m_mode == M_DEAD && !dl_detect_in) ||
             (m_mode == M_REPORT && trace_in && !org_me);
        check_eq("dl_out", 32'(dl_out), 32'(dl));

        po = 0;
        pd = 0;
        to = 1'b0;
        if (dl_detect_in && m_mode != M_REPORT) begin
            m_mode = M_REPORT;
            m_run  = 0;
            m_wait = 0;
        end else begin
            case (m_mode)
                M_FREE: begin
                    if (foreign) begin po = pin; pd = dst; end
                    if (mask != 0) begin m_mode = M_BLOCKED; m_run = 1; end
                end
                M_BLOCKED: begin
                    if (mask == 0) begin
                        m_mode = M_FREE; m_run = 0;
                    end else if (m_run == BT - 1) begin
                        po = own; pd = dst; m_mode = M_PROBING; m_wait = 0;
                    end else begin
                        m_run++;
                        if (foreign) begin po = pin; pd = dst; end
                    end
                end
                M_PROBING: begin
                    if (mask == 0) begin
                        m_mode = M_FREE; m_run = 0; m_wait = 0;
                    end else begin
                        if (foreign) begin po = pin; pd = dst; end
                        if (pin == own) m_mode = M_DEAD;
                        else if (m_wait == PT - 1) begin m_mode = M_BLOCKED; m_run = 0; end
                        else m_wait++;
                    end
                end
                M_DEAD: begin
                end
                default: begin
                    if (token_clear) m_held = 1'b0;
                    else if (org_me) begin to = 1'b1; pd = dst; m_held = 1'b1; end
                    else if (trace_in && !m_held) begin to = 1'b1; pd = dst; end
                end
            endcase
        end
        exp_q.push_back({po[N-1:0], pd[N-1:0], to});
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        dep_vec      = '0;
        probe_in     = '0;
        dl_detect_in = 1'b0;
        origin       = '0;
        token_clear  = 1'b0;
        trace_in     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clock);
        do_reset();

        // Sustained block: launch at cycle 16, timeout, re-probe 16 later.
        dep_vec = 2'b10;
        repeat (60) cycle();

        // Foreign probe arriving on the launch cycle loses to the own probe.
        clear_inputs();
        do_reset();
        dep_vec = 2'b11;
        for (int i = 0; i < 20; i++) begin
            probe_in = (m_mode == M_BLOCKED && m_run == BT - 1) ? 2'b10 : 2'b00;
            cycle();
        end

        // Own probe loops back -> DL, then global detect and trace sequence.
        clear_inputs();
        do_reset();
        dep_vec = 2'b10;
        for (int i = 0; i < 30; i++) begin
            probe_in = (m_mode == M_PROBING && m_wait == 2) ? 2'b01 : 2'b00;
            cycle();
        end
        probe_in = '0;
        repeat (4) cycle();
        dl_detect_in = 1'b1;
        cycle();
        repeat (2) cycle();
        origin = 2'b01; cycle();
        origin = 2'b00; cycle();
        cycle();
        trace_in = 1'b1; cycle();
        trace_in = 1'b0; cycle();
        token_clear = 1'b1; cycle();
        token_clear = 1'b0; trace_in = 1'b1; cycle();
        trace_in = 1'b0; cycle();
        trace_in = 1'b1; origin = 2'b01; cycle();
        origin = 2'b00; trace_in = 1'b0; cycle();
        trace_in = 1'b1; token_clear = 1'b1; cycle();
        trace_in = 1'b0; token_clear = 1'b0; cycle();
        origin = 2'b10; trace_in = 1'b1; cycle();
        origin = 2'b00; trace_in = 1'b0; repeat (2) cycle();

        // Reset while the launched probe is still on the outputs.
        clear_inputs();
        do_reset();
        dep_vec = 2'b10;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (m_mode == M_PROBING) break;
        end
        do_reset();
        clear_inputs();
        repeat (3) cycle();

        // Randomized traffic with occasional mid-run resets.
        for (int seg = 0; seg < 6; seg++) begin
            clear_inputs();
            do_reset();
            for (int i = 0; i < 300; i++) begin
                int r;
                if ($urandom_range(0, 15) == 0) dep_vec = N'($urandom_range(0, 3));
                r = $urandom_range(0, 15);
                if (m_mode == M_PROBING && r < 3) probe_in = 2'b01;
                else if (r == 4) probe_in = 2'b10;
                else if (r == 5) probe_in = 2'b01;
                else probe_in = 2'b00;
                if ($urandom_range(0, 399) == 0) dl_detect_in = 1'b1;
                if (m_mode == M_DEAD && $urandom_range(0, 7) == 0) dl_detect_in = 1'b1;
                r = $urandom_range(0, 19);
                origin      = (r == 0) ? 2'b01 : ((r == 1) ? 2'b10 : 2'b00);
                trace_in    = ($urandom_range(0, 5) == 0);
                token_clear = ($urandom_range(0, 9) == 0);
                cycle();
                if ($urandom_range(0, 249) == 0) begin
                    do_reset();
                    dl_detect_in = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
